// File: rtl/dffram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a 128x8 single-port DFF RAM.
// Accepts one byte access per cycle and returns a completion pulse to the owner one cycle after issue.

module dffram_arbiter_lane #(
  parameter int DATA_W  = 8,
  parameter bit PORT_ID = 1'b0
) (
  input  logic              ena,
  input  logic              req_valid,
  input  logic              peer_valid,
  input  logic              last,
  input  logic              cmp_vld,
  input  logic              cmp_owner,
  input  logic              cmp_read,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              grant,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata
);
  // Under contention the port that did not win last time goes first.
  assign grant     = ena & req_valid & (~peer_valid | (last != PORT_ID));
  assign rsp_valid = cmp_vld & (cmp_owner == PORT_ID);
  assign rsp_rdata = (rsp_valid & cmp_read) ? ram_rdata : '0;
endmodule

module dffram_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic              req0_we,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int NUM_PORTS = 2;
  localparam int STAGES    = 2;

  logic [NUM_PORTS-1:0]             req_valid, req_we, grant, rsp_valid;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata, rsp_rdata;
  logic [STAGES:1]                  vld_pipe;
  logic                             last, accept, sel;
  logic                             iss_owner, iss_read, cmp_owner, cmp_read;

  assign req_valid = {req1_valid, req0_valid};
  assign req_we    = {req1_we, req0_we};
  assign req_addr  = {req1_addr, req0_addr};
  assign req_wdata = {req1_wdata, req0_wdata};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    dffram_arbiter_lane #(.DATA_W(DATA_W), .PORT_ID(1'(i))) u_lane (
      .ena        (ena),
      .req_valid  (req_valid[i]),
      .peer_valid (req_valid[NUM_PORTS-1-i]),
      .last       (last),
      .cmp_vld    (vld_pipe[STAGES]),
      .cmp_owner  (cmp_owner),
      .cmp_read   (cmp_read),
      .ram_rdata  (ram_rdata),
      .grant      (grant[i]),
      .rsp_valid  (rsp_valid[i]),
      .rsp_rdata  (rsp_rdata[i])
    );
  end

  assign accept     = |grant;
  assign sel        = grant[1];
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_rdata = rsp_rdata[0];
  assign rsp1_rdata = rsp_rdata[1];
  assign ram_en     = vld_pipe[1];

  // Issue stage feeds the RAM directly; completion stage lines up with ram_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= 1'b1;
      vld_pipe  <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      iss_owner <= 1'b0;
      iss_read  <= 1'b0;
      cmp_owner <= 1'b0;
      cmp_read  <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], accept};
      ram_we    <= accept & req_we[sel];
      cmp_owner <= iss_owner;
      cmp_read  <= iss_read;
      if (accept) begin
        last      <= sel;
        ram_addr  <= req_addr[sel];
        ram_wdata <= req_wdata[sel];
        iss_owner <= sel;
        iss_read  <= ~req_we[sel];
      end
    end
  end
endmodule
